cvtb_pkt_tx: RTL and testbench

Transmit-side drain engine for the convertible packet buffer. When the CPU/control path signals that a stored packet is ready, it reads the packet from a single-port buffer memory, from head address to tail address inclusive and wrapping modulo depth. It emits the words on the NetFPGA-style out_data/out_ctrl/out_wr/out_rdy interface toward the next pipeline stage, then pulses done so the buffer can be released back to the receive side.

---
 rtl/cvtb_pkt_tx.sv | 171 +++++++++++++++++
 tb/tb_cvtb_pkt_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvtb_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : cvtb_pkt_tx
// Description : Transmit drain engine for the convertible packet buffer.
//               Reads a stored packet [head..tail] (inclusive, wrapping)
//               from single-port memory and streams it out on an
//               out_data/out_ctrl/out_wr/out_rdy interface with a 2-entry
//               fall-through buffer that absorbs the one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cvtb_pkt_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            head_addr,
  input  logic [ADDR_WIDTH-1:0]            tail_addr,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_rd,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH:0]              words_sent
);

  localparam int                CNT_W  = ADDR_WIDTH + 1;
  localparam int                WORD_W = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [CNT_W-1:0]  c_one  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_rem_rd;
  logic [CNT_W-1:0]      r_rem_wr;
  logic [CNT_W-1:0]      r_words_sent;
  logic [WORD_W-1:0]     r_buf0;
  logic [WORD_W-1:0]     r_buf1;
  logic [1:0]            r_cnt;
  logic                  r_inflight;

  logic [CNT_W-1:0]      w_len;
  logic                  w_space;
  logic                  w_avail;
  logic                  w_pop;
  logic [WORD_W-1:0]     w_head;

  // Packet length: modular distance head->tail plus one, so tail = head-1 is full depth.
  assign w_len   = {1'b0, tail_addr - head_addr} + c_one;

  // Room for another read only if stored words plus the read in flight stay below 2.
  assign w_space = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && !r_inflight);

  // Head of the output stream: stored word if any, otherwise memory data arriving now.
  assign w_avail = (r_state == S_SEND) && ((r_cnt != 2'd0) || r_inflight);
  assign w_head  = (r_cnt != 2'd0) ? r_buf0 : mem_rdata;
  assign w_pop   = w_avail && out_rdy;

  assign out_wr     = w_pop;
  assign out_data   = w_avail ? w_head[DATA_WIDTH-1:0] : '0;
  assign out_ctrl   = w_avail ? w_head[WORD_W-1:DATA_WIDTH] : '0;
  assign mem_addr   = r_rd_ptr;
  assign words_sent = r_words_sent;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus busy/done/read-issue outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        busy   = 1'b1;
        mem_rd = (r_rem_rd != '0) && w_space;
        if (w_pop && (r_rem_wr == c_one)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read pointer, word counters and the 2-entry fall-through output buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_rem_rd     <= '0;
      r_rem_wr     <= '0;
      r_words_sent <= '0;
      r_buf0       <= '0;
      r_buf1       <= '0;
      r_cnt        <= 2'd0;
      r_inflight   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_rd_ptr     <= head_addr;
        r_rem_rd     <= w_len;
        r_rem_wr     <= w_len;
        r_words_sent <= '0;
      end
      if (mem_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_rem_rd <= r_rem_rd - c_one;
      end
      if (w_pop) begin
        r_rem_wr     <= r_rem_wr - c_one;
        r_words_sent <= r_words_sent + c_one;
      end
      r_inflight <= mem_rd;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_buf0 <= mem_rdata;
          end else begin
            r_buf1 <= mem_rdata;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Empty buffer means the arriving word bypassed straight out.
          if (r_cnt == 2'd1) begin
            r_buf0 <= mem_rdata;
          end else if (r_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cvtb_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cvtb_pkt_tx
// Description : Self-checking bench for cvtb_pkt_tx. A behavioural memory
//               serves reads; expected words are queued when a packet is
//               started and a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cvtb_pkt_tx;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] head_addr;
  logic [AW-1:0] tail_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW+CW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          busy;
  logic          done;
  logic [AW:0]   words_sent;

  cvtb_pkt_tx #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .head_addr(head_addr), .tail_addr(tail_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic [71:0] mem [0:511];
  logic [71:0] exp_q [$];
  int          wr_cyc [$];
  logic [AW-1:0] rd_addr_q [$];
  logic [71:0] mon_e;

  // Buffer image: ctrl byte and data tagged with the address; basic packet ctrl overridden.
  function automatic logic [71:0] expw(input int a);
    logic [8:0] a9;
    logic [7:0] c;
    a9 = a[8:0];
    c  = a9[7:0] ^ 8'h5A;
    case (a)
      16: c = 8'hFF;
      17: c = 8'h00;
      18: c = 8'h00;
      19: c = 8'h01;
      default: ;
    endcase
    return {c, 32'hC0DEF00D, 23'd0, a9};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Memory with one-cycle read latency; junk on non-read cycles exposes mistimed capture.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= {8'hEE, 64'hBADBADBADBADBAD0};
  end

  // Monitor: scoreboard pop on every transferred word, plus event logging.
  always @(negedge clk) begin
    if (mem_rd) rd_addr_q.push_back(mem_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_wr) begin
      wr_cyc.push_back(cyc);
      check("wr_needs_rdy", {79'd0, out_rdy}, 80'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", {out_ctrl, out_data}, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("word", {8'd0, out_ctrl, out_data}, {8'd0, mon_e});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int h, input int t);
    tick();
    start     = 1'b1;
    head_addr = h[AW-1:0];
    tail_addr = t[AW-1:0];
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic queue_pkt(input int h, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(expw((h + k) % 512));
  endtask

  task automatic wait_done(input int n0, input int limit);
    int k;
    k = 0;
    while (done_cnt == n0 && k < limit) begin
      tick();
      k++;
    end
    if (done_cnt == n0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
    end
  endtask

  int         n0;
  int         kk;
  logic [5:0] pat;
  logic [AW-1:0] wrap_exp [4];

  initial begin
    reset = 1'b1; start = 1'b0; head_addr = '0; tail_addr = '0; out_rdy = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = expw(i);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", {79'd0, busy}, 80'd0);
    check("rst_done", {79'd0, done}, 80'd0);
    check("rst_out_wr", {79'd0, out_wr}, 80'd0);
    check("rst_mem_rd", {79'd0, mem_rd}, 80'd0);
    check("rst_mem_addr", {71'd0, mem_addr}, 80'd0);
    check("rst_words_sent", {70'd0, words_sent}, 80'd0);
    check("rst_out_data", {16'd0, out_data}, 80'd0);
    tick();
    reset = 1'b0;

    // Basic 4-word packet with latency check
    wr_cyc.delete(); rd_addr_q.delete(); n0 = done_cnt;
    queue_pkt(16, 4);
    pulse_start(16, 19);
    wait_done(n0, 50);
    check("basic_count", wr_cyc.size(), 4);
    if (wr_cyc.size() > 0) begin
      check("basic_first_wr", wr_cyc[0] - start_cyc, 2);
      check("basic_last_wr", wr_cyc[$] - start_cyc, 5);
    end
    check("basic_done_cyc", done_cyc - start_cyc, 6);
    check("basic_words_sent", {70'd0, words_sent}, 80'd4);
    check("basic_busy_after", {79'd0, busy}, 80'd0);
    check("basic_rd_count", rd_addr_q.size(), 4);

    // Single word
    wr_cyc.delete(); rd_addr_q.delete(); n0 = done_cnt;
    queue_pkt(32, 1);
    pulse_start(32, 32);
    wait_done(n0, 50);
    repeat (4) tick();
    check("single_count", wr_cyc.size(), 1);
    check("single_rd_count", rd_addr_q.size(), 1);
    check("single_done_count", done_cnt - n0, 1);
    check("single_words_sent", {70'd0, words_sent}, 80'd1);

    // Address wrap
    wr_cyc.delete(); rd_addr_q.delete(); n0 = done_cnt;
    wrap_exp[0] = 9'h1FE; wrap_exp[1] = 9'h1FF; wrap_exp[2] = 9'h000; wrap_exp[3] = 9'h001;
    queue_pkt(510, 4);
    pulse_start(510, 1);
    wait_done(n0, 50);
    check("wrap_count", wr_cyc.size(), 4);
    check("wrap_rd_count", rd_addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rd_addr_q.size()) check("wrap_addr", {71'd0, rd_addr_q[i]}, {71'd0, wrap_exp[i]});

    // Backpressure: out_rdy pattern 1,0,0,1,0,1 repeating
    wr_cyc.delete(); n0 = done_cnt; pat = 6'b101001;
    queue_pkt(64, 8);
    tick();
    start = 1'b1; head_addr = 9'h040; tail_addr = 9'h047; start_cyc = cyc; out_rdy = pat[0];
    kk = 1;
    tick();
    start = 1'b0; out_rdy = pat[1];
    while (done_cnt == n0 && kk < 200) begin
      kk++;
      tick();
      out_rdy = pat[kk % 6];
    end
    out_rdy = 1'b1;
    check("bp_done_seen", done_cnt - n0, 1);
    check("bp_count", wr_cyc.size(), 8);
    check("bp_words_sent", {70'd0, words_sent}, 80'd8);
    check("bp_queue_empty", exp_q.size(), 0);

    // Start while busy is ignored
    wr_cyc.delete(); n0 = done_cnt;
    queue_pkt(96, 8);
    pulse_start(96, 103);
    repeat (2) tick();
    start = 1'b1; head_addr = 9'h100; tail_addr = 9'h101;
    tick();
    start = 1'b0;
    wait_done(n0, 50);
    repeat (10) tick();
    check("busy_start_done_count", done_cnt - n0, 1);
    check("busy_start_count", wr_cyc.size(), 8);
    check("busy_start_words_sent", {70'd0, words_sent}, 80'd8);

    // Reset after 3 of 8 words, then a clean 2-word packet
    wr_cyc.delete(); n0 = done_cnt;
    queue_pkt(128, 8);
    pulse_start(128, 135);
    kk = 0;
    while (wr_cyc.size() < 3 && kk < 50) begin
      tick();
      kk++;
    end
    check("mid_reached_3", wr_cyc.size(), 3);
    out_rdy = 1'b0; reset = 1'b1;
    exp_q.delete();
    tick();
    out_rdy = 1'b1; reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_wr", {79'd0, out_wr}, 80'd0);
    check("mid_rst_busy", {79'd0, busy}, 80'd0);
    check("mid_rst_words_sent", {70'd0, words_sent}, 80'd0);
    repeat (4) tick();
    check("mid_rst_no_more_wr", wr_cyc.size(), 3);
    wr_cyc.delete(); n0 = done_cnt;
    queue_pkt(160, 2);
    pulse_start(160, 161);
    wait_done(n0, 50);
    repeat (3) tick();
    check("post_rst_count", wr_cyc.size(), 2);
    check("post_rst_words_sent", {70'd0, words_sent}, 80'd2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
